// File: rtl/pht_update_queue_pkg.sv
// Shared fetch-unit types for gshare PHT training: widths, queue entry layout,
// and the index/counter helper functions.
package pht_update_queue_pkg;

  localparam int PC_WIDTH                        = 32;
  localparam int INSN_ADDR_BIT_WIDTH             = 2;
  localparam int BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 10;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH         = 10;
  localparam int PHT_ENTRY_WIDTH                 = 2;
  localparam int PHT_QUEUE_SIZE                  = 32;

  typedef logic [PC_WIDTH-1:0]                        PC_Path;
  typedef logic [BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]         PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0]                 PHT_EntryPath;
  typedef logic [$clog2(PHT_QUEUE_SIZE)-1:0]          PhtQueuePointerPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;

  typedef struct packed {
    PHT_IndexPath phtWA;
    PHT_EntryPath phtWV;
  } PhtQueueEntry;

  // History is zero-extended (or truncated) to the index width before the XOR.
  function automatic PHT_IndexPath ToPHT_Index(input PC_Path addr, input BranchGlobalHistoryPath hist);
    PC_Path shifted;
    shifted = addr >> INSN_ADDR_BIT_WIDTH;
    return shifted[PHT_ENTRY_NUM_BIT_WIDTH-1:0] ^ PHT_IndexPath'(hist);
  endfunction

  function automatic PHT_EntryPath PhtSatUpdate(input PHT_EntryPath prev, input logic taken);
    PHT_EntryPath result;
    if (taken) begin
      result = (prev == PHT_ENTRY_MAX) ? PHT_ENTRY_MAX : prev + PHT_EntryPath'(1);
    end else begin
      result = (prev == '0) ? '0 : prev - PHT_EntryPath'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/pht_update_queue_ram.sv
// Queue storage: one write port, an async read at head for draining and an
// async read at tail-1 for read-modify coalescing.
module pht_update_queue_ram
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = PHT_QUEUE_SIZE
) (
  input  logic                           clk,
  input  logic                           writeEn,
  input  logic [$clog2(QUEUE_DEPTH)-1:0] writePtr,
  input  PhtQueueEntry                   writeEntry,
  input  logic [$clog2(QUEUE_DEPTH)-1:0] headPtr,
  output PhtQueueEntry                   headEntry,
  input  logic [$clog2(QUEUE_DEPTH)-1:0] lastPtr,
  output PhtQueueEntry                   lastEntry
);

  PhtQueueEntry entryArray [QUEUE_DEPTH];

  always_ff @(posedge clk) begin
    if (writeEn) begin
      entryArray[writePtr] <= writeEntry;
    end
  end

  assign headEntry = entryArray[headPtr];
  assign lastEntry = entryArray[lastPtr];

endmodule

// File: rtl/pht_update_queue.sv
// Buffers gshare PHT counter updates from branch resolution and drains them
// through the shared PHT port whenever no read is using it.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH    = PHT_QUEUE_SIZE,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 brResultValid,
  input  PC_Path                               brAddr,
  input  BranchGlobalHistoryPath               brGlobalHistory,
  input  logic                                 brExecTaken,
  input  PHT_EntryPath                         brPhtPrevValue,
  input  logic                                 brIsCondBr,
  input  logic                                 brIsAX,
  input  logic                                 phtReadBusy,
  output logic                                 phtWE,
  output PHT_IndexPath                         phtWA,
  output PHT_EntryPath                         phtWV,
  output logic [$clog2(QUEUE_DEPTH):0]         queueCount,
  output logic                                 queueFull,
  output logic                                 queueEmpty,
  output logic [DROP_CNT_WIDTH-1:0]            dropCount
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] PtrPath;
  typedef logic [CNT_W-1:0] CountPath;

  PtrPath                    headPtrReg, headPtrNext;
  PtrPath                    tailPtrReg, tailPtrNext;
  PtrPath                    lastPtr, writePtr;
  CountPath                  countReg, countNext;
  logic [DROP_CNT_WIDTH-1:0] dropCountReg, dropCountNext;

  PhtQueueEntry headEntry, lastEntry, writeEntry;
  PHT_IndexPath updIndex;
  logic         writeEn;
  logic         eligible, isEmpty, isFull;
  logic         doPop, doCoalesce, doPush, doDrop;

  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == CountPath'(QUEUE_DEPTH));
  assign lastPtr = tailPtrReg - PtrPath'(1);

  pht_update_queue_ram #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) queueRam (
    .clk       (clk),
    .writeEn   (writeEn),
    .writePtr  (writePtr),
    .writeEntry(writeEntry),
    .headPtr   (headPtrReg),
    .headEntry (headEntry),
    .lastPtr   (lastPtr),
    .lastEntry (lastEntry)
  );

  always_comb begin
    eligible      = brResultValid && brIsCondBr && !brIsAX;
    updIndex      = ToPHT_Index(brAddr, brGlobalHistory);
    doPop         = !isEmpty && !phtReadBusy;
    // The tail-1 entry is off limits once it is leaving the queue this cycle.
    doCoalesce    = eligible && !isEmpty && (lastEntry.phtWA == updIndex) &&
                    !(doPop && (countReg == CountPath'(1)));
    doPush        = eligible && !doCoalesce && (!isFull || doPop);
    doDrop        = eligible && !doCoalesce && isFull && !doPop;

    writeEn       = doPush || doCoalesce;
    writePtr      = doCoalesce ? lastPtr : tailPtrReg;
    writeEntry.phtWA = updIndex;
    writeEntry.phtWV = PhtSatUpdate(doCoalesce ? lastEntry.phtWV : brPhtPrevValue, brExecTaken);

    headPtrNext   = doPop  ? headPtrReg + PtrPath'(1) : headPtrReg;
    tailPtrNext   = doPush ? tailPtrReg + PtrPath'(1) : tailPtrReg;

    countNext = countReg;
    case ({doPush, doPop})
      2'b10:   countNext = countReg + CountPath'(1);
      2'b01:   countNext = countReg - CountPath'(1);
      default: countNext = countReg;
    endcase

    dropCountNext = dropCountReg;
    if (doDrop && (dropCountReg != '1)) begin
      dropCountNext = dropCountReg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtrReg   <= '0;
      tailPtrReg   <= '0;
      countReg     <= '0;
      dropCountReg <= '0;
    end else begin
      headPtrReg   <= headPtrNext;
      tailPtrReg   <= tailPtrNext;
      countReg     <= countNext;
      dropCountReg <= dropCountNext;
    end
  end

  // Head data is forced to zero while empty so stale storage never shows.
  assign phtWE      = doPop;
  assign phtWA      = isEmpty ? '0 : headEntry.phtWA;
  assign phtWV      = isEmpty ? '0 : headEntry.phtWV;
  assign queueCount = countReg;
  assign queueFull  = isFull;
  assign queueEmpty = isEmpty;
  assign dropCount  = dropCountReg;

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed and randomized checks of pht_update_queue against a queue-based
// reference model of the PHT update stream.
module tb_pht_update_queue;
  import pht_update_queue_pkg::*;

  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         brResultValid;
  logic [31:0]  brAddr;
  logic [9:0]   brGlobalHistory;
  logic         brExecTaken;
  logic [1:0]   brPhtPrevValue;
  logic         brIsCondBr;
  logic         brIsAX;
  logic         phtReadBusy;
  logic         phtWE;
  logic [9:0]   phtWA;
  logic [1:0]   phtWV;
  logic [5:0]   queueCount;
  logic         queueFull;
  logic         queueEmpty;
  logic [15:0]  dropCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] idx;
    logic [1:0] val;
  } ent_t;

  ent_t mq[$];
  int   mDrop = 0;

  pht_update_queue #(.QUEUE_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .brResultValid  (brResultValid),
    .brAddr         (brAddr),
    .brGlobalHistory(brGlobalHistory),
    .brExecTaken    (brExecTaken),
    .brPhtPrevValue (brPhtPrevValue),
    .brIsCondBr     (brIsCondBr),
    .brIsAX         (brIsAX),
    .phtReadBusy    (phtReadBusy),
    .phtWE          (phtWE),
    .phtWA          (phtWA),
    .phtWV          (phtWV),
    .queueCount     (queueCount),
    .queueFull      (queueFull),
    .queueEmpty     (queueEmpty),
    .dropCount      (dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] satModel(input logic [1:0] p, input logic t);
    int v;
    v = t ? p + 1 : p - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic logic [9:0] idxModel(input logic [31:0] a, input logic [9:0] h);
    logic [31:0] tmp;
    tmp = (a / 4) ^ {22'b0, h};
    return tmp[9:0];
  endfunction

  task automatic modelStep();
    bit   pop;
    ent_t e;
    pop = (mq.size() > 0) && !phtReadBusy;
    if (brResultValid && brIsCondBr && !brIsAX) begin
      e.idx = idxModel(brAddr, brGlobalHistory);
      if (mq.size() > 0 && mq[mq.size()-1].idx == e.idx && !(pop && mq.size() == 1)) begin
        e.val = satModel(mq[mq.size()-1].val, brExecTaken);
        mq[mq.size()-1] = e;
      end else if (mq.size() < DEPTH || pop) begin
        e.val = satModel(brPhtPrevValue, brExecTaken);
        mq.push_back(e);
      end else if (mDrop < 65535) begin
        mDrop++;
      end
    end
    if (pop) void'(mq.pop_front());
  endtask

  task automatic checkOut(input string tag);
    logic expWE;
    expWE = (mq.size() > 0) && !phtReadBusy;
    chk({tag, ".we"}, 32'(phtWE), 32'(expWE));
    if (expWE) begin
      chk({tag, ".wa"}, 32'(phtWA), 32'(mq[0].idx));
      chk({tag, ".wv"}, 32'(phtWV), 32'(mq[0].val));
    end
    chk({tag, ".count"}, 32'(queueCount), 32'(mq.size()));
    chk({tag, ".full"},  32'(queueFull),  32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(queueEmpty), 32'(mq.size() == 0));
    chk({tag, ".drop"},  32'(dropCount),  32'(mDrop));
    $display("cycle %s: busy=%0b in=%0b we=%0b wa=0x%0h wv=%0d count=%0d drop=%0d",
             tag, phtReadBusy, brResultValid, phtWE, phtWA, phtWV, queueCount, dropCount);
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle(input string tag);
    #1;
    checkOut(tag);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic setUpd(input logic [31:0] a, input logic [9:0] h, input logic t,
                        input logic [1:0] p, input logic busy);
    brResultValid = 1'b1; brAddr = a; brGlobalHistory = h; brExecTaken = t;
    brPhtPrevValue = p; brIsCondBr = 1'b1; brIsAX = 1'b0; phtReadBusy = busy;
  endtask

  task automatic setIdle(input logic busy);
    brResultValid = 1'b0; brAddr = '0; brGlobalHistory = '0; brExecTaken = 1'b0;
    brPhtPrevValue = '0; brIsCondBr = 1'b0; brIsAX = 1'b0; phtReadBusy = busy;
  endtask

  initial begin
    rst_n = 1'b0;
    setIdle(1'b0);
    #12;
    chk("reset.we",    32'(phtWE), 0);
    chk("reset.count", 32'(queueCount), 0);
    chk("reset.empty", 32'(queueEmpty), 1);
    chk("reset.full",  32'(queueFull), 0);
    chk("reset.drop",  32'(dropCount), 0);
    chk("reset.wa",    32'(phtWA), 0);
    chk("reset.wv",    32'(phtWV), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single update, no same-cycle bypass
    setUpd(32'h100, 10'h3, 1'b1, 2'd1, 1'b0);
    #1 chk("single.nobypass", 32'(phtWE), 0);
    cycle("single.in");
    setIdle(1'b0);
    #1;
    chk("single.we", 32'(phtWE), 1);
    chk("single.wa", 32'(phtWA), 32'h43);
    chk("single.wv", 32'(phtWV), 2);
    cycle("single.out");
    cycle("single.after");

    // Saturation at both ends
    setUpd(32'h200, 10'h0, 1'b1, 2'd3, 1'b0);
    cycle("sat.hi.in");
    setUpd(32'h300, 10'h0, 1'b0, 2'd0, 1'b0);
    #1 chk("sat.hi.wv", 32'(phtWV), 3);
    cycle("sat.hi.out");
    setIdle(1'b0);
    #1 chk("sat.lo.wv", 32'(phtWV), 0);
    cycle("sat.lo.out");

    // Filtered inputs
    setUpd(32'h500, 10'h0, 1'b1, 2'd1, 1'b1);
    brIsAX = 1'b1;
    cycle("filter.ax");
    setUpd(32'h504, 10'h0, 1'b1, 2'd1, 1'b1);
    brIsCondBr = 1'b0;
    cycle("filter.uncond");
    setIdle(1'b1);
    #1 chk("filter.count", 32'(queueCount), 0);
    cycle("filter.idle");

    // Coalesce under read pressure
    setUpd(32'h400, 10'h0, 1'b1, 2'd0, 1'b1);
    cycle("coal.a");
    setUpd(32'h400, 10'h0, 1'b1, 2'd0, 1'b1);
    cycle("coal.b");
    setIdle(1'b1);
    #1 chk("coal.count", 32'(queueCount), 1);
    cycle("coal.hold");
    setIdle(1'b0);
    #1;
    chk("coal.we", 32'(phtWE), 1);
    chk("coal.wa", 32'(phtWA), 32'h100);
    chk("coal.wv", 32'(phtWV), 2);
    cycle("coal.drain");
    cycle("coal.empty");

    // Fill, drop, then push alongside pop while full
    for (int i = 0; i < 34; i++) begin
      setUpd(32'(i) << 2, 10'h0, 1'b1, 2'd1, 1'b1);
      cycle($sformatf("fill.%0d", i));
    end
    setIdle(1'b1);
    #1;
    chk("full.flag",  32'(queueFull), 1);
    chk("full.count", 32'(queueCount), 32);
    chk("full.drop",  32'(dropCount), 2);
    cycle("full.hold");
    setUpd(32'd100 << 2, 10'h0, 1'b0, 2'd2, 1'b0);
    #1;
    chk("fullpop.we", 32'(phtWE), 1);
    chk("fullpop.wa", 32'(phtWA), 0);
    cycle("fullpop.in");
    setIdle(1'b0);
    #1;
    chk("fullpop.count", 32'(queueCount), 32);
    chk("fullpop.drop",  32'(dropCount), 2);
    for (int i = 0; i < 33; i++) cycle($sformatf("drain.%0d", i));

    // Asynchronous reset with pending entries
    for (int i = 0; i < 5; i++) begin
      setUpd(32'h1000 + (32'(i) << 2), 10'h0, 1'b1, 2'd1, 1'b1);
      cycle($sformatf("pre.%0d", i));
    end
    setIdle(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.count", 32'(queueCount), 0);
    chk("midrst.we",    32'(phtWE), 0);
    chk("midrst.empty", 32'(queueEmpty), 1);
    chk("midrst.drop",  32'(dropCount), 0);
    mq.delete();
    mDrop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("postrst.%0d", i));

    // Randomized traffic: heavy read pressure first, then light
    for (int i = 0; i < 400; i++) begin
      brResultValid   = ($urandom_range(0, 9) != 0);
      brAddr          = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2) |
                        32'($urandom_range(0, 3));
      brGlobalHistory = 10'($urandom_range(0, 3));
      brExecTaken     = 1'($urandom);
      brPhtPrevValue  = 2'($urandom);
      brIsCondBr      = ($urandom_range(0, 7) != 0);
      brIsAX          = ($urandom_range(0, 7) == 0);
      phtReadBusy     = ($urandom_range(0, 99) < ((i < 200) ? 85 : 25));
      cycle($sformatf("rand.%0d", i));
    end
    setIdle(1'b0);
    for (int i = 0; i < 34; i++) cycle($sformatf("final.%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Sits between branch resolution and the gshare PHT write port.
- Takes one resolved BranchResult per cycle and computes the gshare PHT index and the saturated 2-bit counter value.
- Buffers the resulting writes in a circular queue and drains them whenever the PHT read path leaves the single write port free.
- Filters out unconditional and approximate (isAX) branches, and coalesces back-to-back updates to the same PHT entry.

Parameters:
- QUEUE_DEPTH, PHT_QUEUE_SIZE (32), number of queue entries; must be a power of 2, at least 2.
- DROP_CNT_WIDTH, 16, width of the saturating dropped-update counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- brResultValid  in  1  a resolved branch is presented this cycle.
- brAddr  in  PC_WIDTH  PC of the resolved branch.
- brGlobalHistory  in  BRANCH_GLOBAL_HISTORY_BIT_WIDTH  history used at prediction time.
- brExecTaken  in  1  actual direction.
- brPhtPrevValue  in  PHT_ENTRY_WIDTH  counter value read at prediction time.
- brIsCondBr  in  1  conditional branch.
- brIsAX  in  1  approximate branch; excluded from training.
- phtReadBusy  in  1  PHT port is used for a read this cycle; no write allowed.
- phtWE  out  1  PHT write enable.
- phtWA  out  PHT_ENTRY_NUM_BIT_WIDTH  PHT write index.
- phtWV  out  PHT_ENTRY_WIDTH  PHT write value.
- queueCount  out  $clog2(QUEUE_DEPTH)+1  number of valid entries.
- queueFull  out  1  queueCount == QUEUE_DEPTH.
- queueEmpty  out  1  queueCount == 0.
- dropCount  out  DROP_CNT_WIDTH  saturating count of discarded updates.

Behaviour:
- Reset (async, rst_n=0): head=tail=0, queueCount=0, dropCount=0. Outputs during reset: phtWE=0, queueEmpty=1, queueFull=0. phtWA and phtWV are don't-care but driven 0. Reset mid-operation discards all pending entries.
- Eligibility: an update is eligible iff brResultValid && brIsCondBr && !brIsAX. Ineligible inputs have no effect.
- Index: idx = (brAddr >> INSN_ADDR_BIT_WIDTH) XOR zero-extended brGlobalHistory, truncated to PHT_ENTRY_NUM_BIT_WIDTH.
- Value: if taken, min(prev+1, PHT_ENTRY_MAX); else max(prev-1, 0). Saturating 2-bit arithmetic; prev=3 taken gives 3, prev=0 not-taken gives 0.
- Drain (combinational from head): phtWE = !queueEmpty && !phtReadBusy. phtWA/phtWV = head entry. Pop on phtWE.
- Latency: an eligible update at cycle t is at earliest written at t+1. There is no same-cycle bypass.
- Coalesce: an eligible update matches when the queue is non-empty, idx equals the entry at tail-1, and that entry is not being popped this cycle. On a match the entry is overwritten in place.
  - The new value is computed from the stored value, not from brPhtPrevValue.
  - No push occurs and queueCount is unchanged.
- Push: an eligible, non-coalesced update with room is written at tail and tail increments, wrapping mod QUEUE_DEPTH.
  - Room means queueCount < QUEUE_DEPTH, or a pop happens in the same cycle.
- Full: an eligible, non-coalesced update with no room and no same-cycle pop is dropped. dropCount += 1, saturating at all-ones.
- Simultaneous push and pop: queueCount is unchanged and both pointers advance. On empty, the head entry is never the incoming one in the same cycle.
- Coalescing with a single-entry queue that is being popped is forbidden. In that case a normal push occurs.
- Pointers wrap naturally. queueCount is tracked explicitly, so full and empty are unambiguous.
- Both queueFull and queueEmpty derive from the registered queueCount.

Decomposition:
- Add to FetchUnitTypes:
  - PhtQueueEntry, with phtWA narrowed to PHT_IndexPath.
  - function ToPHT_Index(PC_Path, BranchGlobalHistoryPath).
  - function PhtSatUpdate(PHT_EntryPath, logic taken).
  - PhtQueuePointerPath, already present.
- One sub-module is natural: pht_queue_ram, a QUEUE_DEPTH x PhtQueueEntry storage with 1 write, 1 async read and 1 read-modify port for tail-1. Pointers, counters and control stay in the top module.

Test Plan:
- Reset then idle: rst_n low mid-stream with 5 entries queued -> after release phtWE=0, queueCount=0, dropCount=0, and no stale write appears.
- Single update: brAddr=0x100, history=0x3, taken, prev=1, phtReadBusy=0 -> next cycle phtWE=1, phtWA=(0x40 XOR 0x3) truncated, phtWV=2. Following cycle queueEmpty=1.
- Saturation and filter:
  - prev=3 taken -> phtWV=3.
  - prev=0 not-taken -> phtWV=0.
  - brIsAX=1 or brIsCondBr=0 -> no write and queueCount unchanged.
- Coalesce: phtReadBusy=1, two consecutive taken updates to the same idx, first prev=0 -> queueCount=1. After busy drops, a single write with phtWV=2 occurs.
- Full/drop: phtReadBusy=1, 34 distinct eligible updates -> queueFull after 32 and dropCount=2. Then release busy -> 32 writes in FIFO order, with pointers wrapping correctly.
- Full plus simultaneous pop: queue full, phtReadBusy=0, new distinct update -> accepted, queueCount stays 32, dropCount unchanged.
